// File: rtl/philv_trace_buffer.sv
// Retire-trace FIFO for philosophy_v_core: bounded run window, drain, done.
// Optional define PHILV_TRACE_TIMESTAMP_EN stores the capture cycle with each record.
module philv_trace_buffer #(
    parameter int DEPTH      = 16,
    parameter int XLEN       = 32,
    parameter int MAX_CYCLES = 500
) (
    input  logic                   clk,
    input  logic                   rstb,
    input  logic                   cap_valid,
    input  logic [XLEN-1:0]        cap_pc,
    input  logic [XLEN-1:0]        cap_instr,
    input  logic [4:0]             cap_rd,
    input  logic                   cap_we,
    input  logic [XLEN-1:0]        cap_wdata,
    output logic                   run_en,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [XLEN-1:0]        rd_pc,
    output logic [XLEN-1:0]        rd_instr,
    output logic [XLEN-1:0]        rd_wdata,
    output logic [4:0]             rd_rd,
    output logic                   rd_we,
    output logic [31:0]            rd_cycle,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic [15:0]            drop_count,
    output logic                   done
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam bit LIMITED = (MAX_CYCLES != 0);
    localparam logic [31:0] LAST_CYCLE = LIMITED ? 32'(MAX_CYCLES - 1) : 32'd0;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t          state_r;
    logic [31:0]     cycle_r;
    logic            run_en_r;
    logic            done_r;

    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [CW-1:0]   count_r;
    logic            rd_valid_r;
    logic            overflow_r;
    logic [15:0]     drop_count_r;

    logic [XLEN-1:0] pc_mem_r    [DEPTH];
    logic [XLEN-1:0] instr_mem_r [DEPTH];
    logic [XLEN-1:0] wdata_mem_r [DEPTH];
    logic [4:0]      rd_mem_r    [DEPTH];
    logic            we_mem_r    [DEPTH];

    logic [XLEN-1:0] rd_pc_r;
    logic [XLEN-1:0] rd_instr_r;
    logic [XLEN-1:0] rd_wdata_r;
    logic [4:0]      rd_rd_r;
    logic            rd_we_r;

    logic            full_s;
    logic            pop_s;
    logic            push_s;
    logic            drop_s;
    logic            bypass_s;
    logic [AW-1:0]   rd_ptr_nxt_s;
    logic [CW-1:0]   count_nxt_s;
    logic [XLEN-1:0] head_pc_s;
    logic [XLEN-1:0] head_instr_s;
    logic [XLEN-1:0] head_wdata_s;
    logic [4:0]      head_rd_s;
    logic            head_we_s;

    // Handshake decode and next-head selection (a push into the slot becoming head bypasses storage).
    always_comb begin
        full_s   = (count_r == FULL_COUNT);
        pop_s    = rd_valid_r & rd_ready;
        push_s   = cap_valid & run_en_r & (~full_s | pop_s);
        drop_s   = cap_valid & run_en_r & full_s & ~pop_s;

        if (pop_s) begin
            rd_ptr_nxt_s = rd_ptr_r + AW'(1);
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end

        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CW'(1);
            2'b01:   count_nxt_s = count_r - CW'(1);
            default: count_nxt_s = count_r;
        endcase

        bypass_s = push_s & (wr_ptr_r == rd_ptr_nxt_s);

        if (count_nxt_s == CW'(0)) begin
            head_pc_s    = {XLEN{1'b0}};
            head_instr_s = {XLEN{1'b0}};
            head_wdata_s = {XLEN{1'b0}};
            head_rd_s    = 5'd0;
            head_we_s    = 1'b0;
        end else if (bypass_s) begin
            head_pc_s    = cap_pc;
            head_instr_s = cap_instr;
            head_wdata_s = cap_wdata;
            head_rd_s    = cap_rd;
            head_we_s    = cap_we;
        end else begin
            head_pc_s    = pc_mem_r[rd_ptr_nxt_s];
            head_instr_s = instr_mem_r[rd_ptr_nxt_s];
            head_wdata_s = wdata_mem_r[rd_ptr_nxt_s];
            head_rd_s    = rd_mem_r[rd_ptr_nxt_s];
            head_we_s    = we_mem_r[rd_ptr_nxt_s];
        end
    end

    // Record storage, written only on accepted captures.
    always_ff @(posedge clk) begin
        if (push_s) begin
            pc_mem_r[wr_ptr_r]    <= cap_pc;
            instr_mem_r[wr_ptr_r] <= cap_instr;
            wdata_mem_r[wr_ptr_r] <= cap_wdata;
            rd_mem_r[wr_ptr_r]    <= cap_rd;
            we_mem_r[wr_ptr_r]    <= cap_we;
        end
    end

    // FIFO pointers, occupancy, drop accounting and registered head record.
    always_ff @(posedge clk) begin
        if (rstb) begin
            wr_ptr_r     <= AW'(0);
            rd_ptr_r     <= AW'(0);
            count_r      <= CW'(0);
            rd_valid_r   <= 1'b0;
            overflow_r   <= 1'b0;
            drop_count_r <= 16'd0;
            rd_pc_r      <= {XLEN{1'b0}};
            rd_instr_r   <= {XLEN{1'b0}};
            rd_wdata_r   <= {XLEN{1'b0}};
            rd_rd_r      <= 5'd0;
            rd_we_r      <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            rd_ptr_r   <= rd_ptr_nxt_s;
            count_r    <= count_nxt_s;
            rd_valid_r <= (count_nxt_s != CW'(0));
            if (drop_s) begin
                overflow_r <= 1'b1;
                if (drop_count_r != 16'hFFFF) begin
                    drop_count_r <= drop_count_r + 16'd1;
                end
            end
            rd_pc_r    <= head_pc_s;
            rd_instr_r <= head_instr_s;
            rd_wdata_r <= head_wdata_s;
            rd_rd_r    <= head_rd_s;
            rd_we_r    <= head_we_s;
        end
    end

    // Run-window FSM with registered run_en/done; cycle counter advances only in RUN.
    always_ff @(posedge clk) begin
        if (rstb) begin
            state_r  <= ST_RUN;
            cycle_r  <= 32'd0;
            run_en_r <= 1'b1;
            done_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    cycle_r <= cycle_r + 32'd1;
                    if (LIMITED && (cycle_r == LAST_CYCLE)) begin
                        state_r  <= ST_DRAIN;
                        run_en_r <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (count_r == CW'(0)) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_DONE;
                end
                default: begin
                    // Corrupted encoding: halt the core and let the FIFO drain.
                    state_r  <= ST_DRAIN;
                    run_en_r <= 1'b0;
                    done_r   <= 1'b0;
                end
            endcase
        end
    end

`ifdef PHILV_TRACE_TIMESTAMP_EN
    logic [31:0] stamp_mem_r [DEPTH];
    logic [31:0] rd_cycle_r;
    logic [31:0] head_stamp_s;

    // Head stamp follows the same selection as the other record fields.
    always_comb begin
        if (count_nxt_s == CW'(0)) begin
            head_stamp_s = 32'd0;
        end else if (bypass_s) begin
            head_stamp_s = cycle_r;
        end else begin
            head_stamp_s = stamp_mem_r[rd_ptr_nxt_s];
        end
    end

    // Stamp storage alongside each record.
    always_ff @(posedge clk) begin
        if (push_s) begin
            stamp_mem_r[wr_ptr_r] <= cycle_r;
        end
    end

    // Registered head stamp.
    always_ff @(posedge clk) begin
        if (rstb) begin
            rd_cycle_r <= 32'd0;
        end else begin
            rd_cycle_r <= head_stamp_s;
        end
    end

    assign rd_cycle = rd_cycle_r;
`else
    assign rd_cycle = 32'd0;
`endif

    assign run_en     = run_en_r;
    assign done       = done_r;
    assign rd_valid   = rd_valid_r;
    assign count      = count_r;
    assign overflow   = overflow_r;
    assign drop_count = drop_count_r;
    assign rd_pc      = rd_pc_r;
    assign rd_instr   = rd_instr_r;
    assign rd_wdata   = rd_wdata_r;
    assign rd_rd      = rd_rd_r;
    assign rd_we      = rd_we_r;

endmodule

// File: tb/tb_philv_trace_buffer.sv
// Bench for philv_trace_buffer: directed vector table, multi-cycle sequences,
// and randomized traffic against a queue-based reference model.
module tb_philv_trace_buffer;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;
    localparam int MAXC  = 20;
`ifdef PHILV_TRACE_TIMESTAMP_EN
    localparam bit TS_EN = 1'b1;
`else
    localparam bit TS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstb;
    logic        cap_valid;
    logic [31:0] cap_pc;
    logic [31:0] cap_instr;
    logic [4:0]  cap_rd;
    logic        cap_we;
    logic [31:0] cap_wdata;
    logic        run_en;
    logic        rd_valid;
    logic        rd_ready;
    logic [31:0] rd_pc;
    logic [31:0] rd_instr;
    logic [31:0] rd_wdata;
    logic [4:0]  rd_rd;
    logic        rd_we;
    logic [31:0] rd_cycle;
    logic [2:0]  count;
    logic        overflow;
    logic [15:0] drop_count;
    logic        done;

    int n_checks = 0;
    int n_err    = 0;

    philv_trace_buffer #(.DEPTH(DEPTH), .XLEN(XLEN), .MAX_CYCLES(MAXC)) dut (
        .clk(clk), .rstb(rstb), .cap_valid(cap_valid), .cap_pc(cap_pc),
        .cap_instr(cap_instr), .cap_rd(cap_rd), .cap_we(cap_we), .cap_wdata(cap_wdata),
        .run_en(run_en), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_pc(rd_pc),
        .rd_instr(rd_instr), .rd_wdata(rd_wdata), .rd_rd(rd_rd), .rd_we(rd_we),
        .rd_cycle(rd_cycle), .count(count), .overflow(overflow),
        .drop_count(drop_count), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        bit          cv;
        bit          rdy;
        logic [31:0] pc;
        int          cnt;
        bit          vld;
        logic [31:0] hpc;
        bit          ovf;
        int          drops;
        bit          run;
        bit          dn;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] wdata;
        logic [31:0] stamp;
        logic [4:0]  rd;
        logic        we;
    } rec_t;

    // Reference model: a queue of records plus run/done bookkeeping.
    rec_t mq[$];
    int   m_cycle;
    bit   m_done;
    bit   m_ovf;
    int   m_drops;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic step(input bit rst, input bit cv, input bit rdy, input logic [31:0] pc,
                        input logic [31:0] instr, input logic [31:0] wdata,
                        input logic [4:0] rd, input logic we);
        rstb      = rst;
        cap_valid = cv;
        rd_ready  = rdy;
        cap_pc    = pc;
        cap_instr = instr;
        cap_wdata = wdata;
        cap_rd    = rd;
        cap_we    = we;
        @(posedge clk);
        #1;
    endtask

    task automatic step_s(input bit rst, input bit cv, input bit rdy, input logic [31:0] pc);
        step(rst, cv, rdy, pc, pc ^ 32'h1357_9BDF, ~pc, pc[6:2], pc[2]);
    endtask

    function automatic vec_t v(bit rst, bit cv, bit rdy, logic [31:0] pc, int cnt, bit vld,
                               logic [31:0] hpc, bit ovf, int drops, bit run, bit dn);
        vec_t r;
        r.rst = rst; r.cv = cv; r.rdy = rdy; r.pc = pc; r.cnt = cnt; r.vld = vld;
        r.hpc = hpc; r.ovf = ovf; r.drops = drops; r.run = run; r.dn = dn;
        return r;
    endfunction

    function automatic void model_reset();
        mq.delete();
        m_cycle = 0;
        m_done  = 1'b0;
        m_ovf   = 1'b0;
        m_drops = 0;
    endfunction

    function automatic void model_edge(bit cv, bit rdy, rec_t r);
        bit run  = (m_cycle < MAXC);
        bit full = (mq.size() == DEPTH);
        bit pop  = (mq.size() != 0) && rdy;
        if (!run && mq.size() == 0) m_done = 1'b1;
        if (pop) void'(mq.pop_front());
        if (run && cv) begin
            if (!full || pop) begin
                r.stamp = m_cycle;
                mq.push_back(r);
            end else begin
                m_ovf = 1'b1;
                if (m_drops < 65535) m_drops++;
            end
        end
        if (run) m_cycle++;
    endfunction

    task automatic compare_model();
        chk("m_count", count, mq.size());
        chk("m_rd_valid", rd_valid, mq.size() != 0);
        chk("m_run_en", run_en, m_cycle < MAXC);
        chk("m_done", done, m_done);
        chk("m_overflow", overflow, m_ovf);
        chk("m_drop_count", drop_count, m_drops);
        if (mq.size() != 0) begin
            chk("m_rd_pc", rd_pc, mq[0].pc);
            chk("m_rd_instr", rd_instr, mq[0].instr);
            chk("m_rd_wdata", rd_wdata, mq[0].wdata);
            chk("m_rd_rd", rd_rd, mq[0].rd);
            chk("m_rd_we", rd_we, mq[0].we);
            chk("m_rd_cycle", rd_cycle, TS_EN ? mq[0].stamp : 32'd0);
        end
    endtask

    initial begin
        vec_t tbl[24];
        rec_t r;
        bit   cv;
        bit   rdy;

        rstb = 1'b1; cap_valid = 1'b0; rd_ready = 1'b0; cap_pc = 32'd0;
        cap_instr = 32'd0; cap_wdata = 32'd0; cap_rd = 5'd0; cap_we = 1'b0;

        // Row index = clock edges since reset; run window closes at edge MAXC.
        tbl[0]  = v(1'b1, 1'b0, 1'b0, 32'h0,   0, 1'b0, 32'h0,   1'b0, 0, 1'b1, 1'b0);
        tbl[1]  = v(1'b0, 1'b1, 1'b0, 32'h0,   1, 1'b1, 32'h0,   1'b0, 0, 1'b1, 1'b0);
        tbl[2]  = v(1'b0, 1'b1, 1'b0, 32'h4,   2, 1'b1, 32'h0,   1'b0, 0, 1'b1, 1'b0);
        tbl[3]  = v(1'b0, 1'b1, 1'b0, 32'h8,   3, 1'b1, 32'h0,   1'b0, 0, 1'b1, 1'b0);
        tbl[4]  = v(1'b0, 1'b0, 1'b1, 32'h0,   2, 1'b1, 32'h4,   1'b0, 0, 1'b1, 1'b0);
        tbl[5]  = v(1'b0, 1'b0, 1'b1, 32'h0,   1, 1'b1, 32'h8,   1'b0, 0, 1'b1, 1'b0);
        tbl[6]  = v(1'b0, 1'b0, 1'b1, 32'h0,   0, 1'b0, 32'h0,   1'b0, 0, 1'b1, 1'b0);
        tbl[7]  = v(1'b0, 1'b0, 1'b1, 32'h0,   0, 1'b0, 32'h0,   1'b0, 0, 1'b1, 1'b0);
        tbl[8]  = v(1'b0, 1'b1, 1'b0, 32'h100, 1, 1'b1, 32'h100, 1'b0, 0, 1'b1, 1'b0);
        tbl[9]  = v(1'b0, 1'b1, 1'b0, 32'h104, 2, 1'b1, 32'h100, 1'b0, 0, 1'b1, 1'b0);
        tbl[10] = v(1'b0, 1'b1, 1'b0, 32'h108, 3, 1'b1, 32'h100, 1'b0, 0, 1'b1, 1'b0);
        tbl[11] = v(1'b0, 1'b1, 1'b0, 32'h10C, 4, 1'b1, 32'h100, 1'b0, 0, 1'b1, 1'b0);
        tbl[12] = v(1'b0, 1'b1, 1'b0, 32'h110, 4, 1'b1, 32'h100, 1'b1, 1, 1'b1, 1'b0);
        tbl[13] = v(1'b0, 1'b1, 1'b0, 32'h114, 4, 1'b1, 32'h100, 1'b1, 2, 1'b1, 1'b0);
        tbl[14] = v(1'b0, 1'b1, 1'b1, 32'h200, 4, 1'b1, 32'h104, 1'b1, 2, 1'b1, 1'b0);
        tbl[15] = v(1'b0, 1'b0, 1'b1, 32'h0,   3, 1'b1, 32'h108, 1'b1, 2, 1'b1, 1'b0);
        tbl[16] = v(1'b0, 1'b0, 1'b1, 32'h0,   2, 1'b1, 32'h10C, 1'b1, 2, 1'b1, 1'b0);
        tbl[17] = v(1'b0, 1'b0, 1'b1, 32'h0,   1, 1'b1, 32'h200, 1'b1, 2, 1'b1, 1'b0);
        tbl[18] = v(1'b0, 1'b0, 1'b1, 32'h0,   0, 1'b0, 32'h0,   1'b1, 2, 1'b1, 1'b0);
        tbl[19] = v(1'b0, 1'b0, 1'b0, 32'h0,   0, 1'b0, 32'h0,   1'b1, 2, 1'b1, 1'b0);
        tbl[20] = v(1'b0, 1'b0, 1'b0, 32'h0,   0, 1'b0, 32'h0,   1'b1, 2, 1'b0, 1'b0);
        tbl[21] = v(1'b0, 1'b0, 1'b0, 32'h0,   0, 1'b0, 32'h0,   1'b1, 2, 1'b0, 1'b1);
        tbl[22] = v(1'b0, 1'b1, 1'b0, 32'h300, 0, 1'b0, 32'h0,   1'b1, 2, 1'b0, 1'b1);
        tbl[23] = v(1'b1, 1'b0, 1'b0, 32'h0,   0, 1'b0, 32'h0,   1'b0, 0, 1'b1, 1'b0);

        for (int i = 0; i < 24; i++) begin
            step_s(tbl[i].rst, tbl[i].cv, tbl[i].rdy, tbl[i].pc);
            chk("tbl_count", count, tbl[i].cnt);
            chk("tbl_rd_valid", rd_valid, tbl[i].vld);
            if (tbl[i].vld || tbl[i].rst) chk("tbl_rd_pc", rd_pc, tbl[i].hpc);
            if (tbl[i].rst) chk("tbl_rst_rd_cycle", rd_cycle, 32'd0);
            chk("tbl_overflow", overflow, tbl[i].ovf);
            chk("tbl_drop_count", drop_count, tbl[i].drops);
            chk("tbl_run_en", run_en, tbl[i].run);
            chk("tbl_done", done, tbl[i].dn);
        end

        // Run window, stamps at cycles 3 and 7, capture ignored in DRAIN, done after drain.
        step_s(1'b1, 1'b0, 1'b0, 32'h0);
        for (int t = 1; t <= 3; t++) step_s(1'b0, 1'b0, 1'b0, 32'h0);
        step_s(1'b0, 1'b1, 1'b0, 32'hA000);
        for (int t = 5; t <= 7; t++) step_s(1'b0, 1'b0, 1'b0, 32'h0);
        step_s(1'b0, 1'b1, 1'b0, 32'hB000);
        for (int t = 9; t <= 21; t++) begin
            step_s(1'b0, 1'b0, 1'b0, 32'h0);
            chk("t4_run_en", run_en, t < MAXC);
        end
        chk("t4_done_pending", done, 1'b0);
        step_s(1'b0, 1'b1, 1'b0, 32'hC000);
        chk("t4_ignored_count", count, 3'd2);
        chk("t4_ignored_drops", drop_count, 16'd0);
        chk("t4_head_pc", rd_pc, 32'hA000);
        chk("t4_head_stamp", rd_cycle, TS_EN ? 32'd3 : 32'd0);
        step_s(1'b0, 1'b0, 1'b1, 32'h0);
        chk("t4_second_pc", rd_pc, 32'hB000);
        chk("t4_second_stamp", rd_cycle, TS_EN ? 32'd7 : 32'd0);
        step_s(1'b0, 1'b0, 1'b1, 32'h0);
        chk("t4_empty_count", count, 3'd0);
        chk("t4_done_not_yet", done, 1'b0);
        step_s(1'b0, 1'b0, 1'b0, 32'h0);
        chk("t4_done", done, 1'b1);
        chk("t4_run_en_low", run_en, 1'b0);

        // Reset while draining a full FIFO discards everything.
        step_s(1'b1, 1'b0, 1'b0, 32'h0);
        for (int t = 1; t <= 5; t++) step_s(1'b0, 1'b1, 1'b0, 32'h40 + 32'(t));
        for (int t = 6; t <= 21; t++) step_s(1'b0, 1'b0, 1'b0, 32'h0);
        chk("t5_drain_run_en", run_en, 1'b0);
        chk("t5_drain_count", count, 3'd4);
        chk("t5_drain_overflow", overflow, 1'b1);
        step_s(1'b1, 1'b0, 1'b0, 32'h0);
        chk("t5_count", count, 3'd0);
        chk("t5_rd_valid", rd_valid, 1'b0);
        chk("t5_run_en", run_en, 1'b1);
        chk("t5_overflow", overflow, 1'b0);
        chk("t5_drop_count", drop_count, 16'd0);
        chk("t5_done", done, 1'b0);
        chk("t5_rd_pc", rd_pc, 32'd0);

        // Randomized episodes against the reference model.
        for (int ep = 0; ep < 8; ep++) begin
            step_s(1'b1, 1'b0, 1'b0, 32'h0);
            model_reset();
            compare_model();
            for (int s = 0; s < 45; s++) begin
                cv      = ($urandom_range(0, 99) < 70);
                rdy     = ($urandom_range(0, 99) < (ep < 4 ? 30 : 60));
                r.pc    = $urandom;
                r.instr = $urandom;
                r.wdata = $urandom;
                r.rd    = 5'($urandom);
                r.we    = 1'($urandom);
                r.stamp = 32'd0;
                model_edge(cv, rdy, r);
                step(1'b0, cv, rdy, r.pc, r.instr, r.wdata, r.rd, r.we);
                compare_model();
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
